// File: rtl/sdc_pkg.sv
// rtl/sdc_pkg.sv - shared constants and FSM encoding for the SD card CMD line receiver and writer.
package sdc_pkg;
  localparam int SHORT_LEN = 48;
  localparam int LONG_LEN  = 136;
  localparam int NCR_MAX   = 64;
  localparam logic [6:0] CRC7_POLY = 7'h09;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    RECV       = 2'd2,
    DONE       = 2'd3
  } sdc_state_t;
endpackage

// File: rtl/sdc_crc7.sv
// rtl/sdc_crc7.sv - serial CRC7 (x^7+x^3+1), one bit per en, cleared by clr.
module sdc_crc7
  import sdc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc <= 7'd0;
    end else if (clr) begin
      crc <= 7'd0;
    end else if (en) begin
      crc <= {crc[5:0], 1'b0} ^ ({7{din ^ crc[6]}} & CRC7_POLY);
    end
  end

endmodule

// File: rtl/sdc_response_receiver.sv
// rtl/sdc_response_receiver.sv - CMD line response deserializer with framing, CRC7 and Ncr timeout checks.
module sdc_response_receiver
  import sdc_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         bit_en,
  input  logic         cmd_in,
  input  logic         start_rx,
  input  logic         long_resp,
  input  logic         crc_chk,
  input  logic         abort,
  output logic         busy,
  output logic [135:0] resp,
  output logic         resp_valid,
  output logic         crc_err,
  output logic         frame_err,
  output logic         timeout
);

  localparam int WW = $clog2(NCR_MAX + 1);

  sdc_state_t    state, state_n;
  logic [WW-1:0] wait_cnt;
  logic [7:0]    bit_cnt;
  logic          long_l;
  logic          chk_l;
  logic [6:0]    crc;
  logic [7:0]    last_idx;
  logic [7:0]    crc_lo;
  logic [7:0]    crc_hi;
  logic          crc_en;
  logic          crc_clr;

  assign last_idx = long_l ? 8'(LONG_LEN - 1) : 8'(SHORT_LEN - 1);
  // Long responses skip the 8 header bits; the last 8 bits (CRC + end) are never fed.
  assign crc_lo   = long_l ? 8'd8 : 8'd1;
  assign crc_hi   = long_l ? 8'(LONG_LEN - 9) : 8'(SHORT_LEN - 9);

  assign crc_clr = (state == IDLE) && start_rx;
  assign crc_en  = bit_en && !abort &&
                   (((state == WAIT_START) && !cmd_in && !long_l) ||
                    ((state == RECV) && (bit_cnt >= crc_lo) && (bit_cnt <= crc_hi)));

  sdc_crc7 u_crc7 (
    .clk   (clk),
    .reset (reset),
    .clr   (crc_clr),
    .en    (crc_en),
    .din   (cmd_in),
    .crc   (crc)
  );

  assign busy       = (state != IDLE);
  assign resp_valid = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:       if (start_rx) state_n = WAIT_START;
      WAIT_START: if (bit_en) begin
                    if (!cmd_in)                            state_n = RECV;
                    else if (wait_cnt == WW'(NCR_MAX - 1))  state_n = DONE;
                  end
      RECV:       if (bit_en && (bit_cnt == last_idx)) state_n = DONE;
      DONE:       state_n = IDLE;
      default:    state_n = IDLE;
    endcase
    if (abort && (state != IDLE)) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp      <= '0;
      crc_err   <= 1'b0;
      frame_err <= 1'b0;
      timeout   <= 1'b0;
      wait_cnt  <= '0;
      bit_cnt   <= '0;
      long_l    <= 1'b0;
      chk_l     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_rx) begin
          long_l    <= long_resp;
          chk_l     <= crc_chk;
          resp      <= '0;
          crc_err   <= 1'b0;
          frame_err <= 1'b0;
          timeout   <= 1'b0;
          wait_cnt  <= '0;
          bit_cnt   <= '0;
        end
        WAIT_START: if (bit_en && !abort) begin
          if (!cmd_in) begin
            resp    <= {resp[134:0], 1'b0};
            bit_cnt <= 8'd1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == WW'(NCR_MAX - 1)) timeout <= 1'b1;
          end
        end
        RECV: if (bit_en && !abort) begin
          resp    <= {resp[134:0], cmd_in};
          bit_cnt <= bit_cnt + 8'd1;
          if ((bit_cnt == 8'd1) && cmd_in) frame_err <= 1'b1;
          if (bit_cnt == last_idx) begin
            if (!cmd_in) frame_err <= 1'b1;
            // resp[6:0] holds the received CRC field just before the end bit shifts in
            crc_err <= chk_l && (crc != resp[6:0]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
